scale_lanes: RTL and testbench

//  Parametrised successor of the fixed 4x16-bit attention-score scaler. Multiplies every lane of a

---
 rtl/scale_lanes.sv | 167 ++++++++++++++++
 tb/tb_scale_lanes.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scale_lanes.sv
`default_nettype none
// ============================================================================
//  Module      : scale_lanes
//  Description : Multiplies each signed lane of a bar by a programmable signed
//                fixed-point coefficient, then rounds half-up and saturates.
//                Two-stage valid/ready pipeline with row-end tagging and a
//                sticky saturation flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module scale_lanes #(
    parameter int             LANES     = 4,
    parameter int             DW        = 16,
    parameter int             CW        = 16,
    parameter int             FRAC      = 12,
    parameter int             ROW_BEATS = 16,
    parameter logic [CW-1:0]  COEF_RST  = 16'h0400
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CW-1:0]       cfg_coef,
    input  logic                cfg_load,
    input  logic                sat_clr,
    input  logic [LANES*DW-1:0] in_bar,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [LANES*DW-1:0] out_bar,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                sat_flag
);

    // Full product width and beat-counter width
    localparam int PW   = DW + CW;
    localparam int CNTW = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;

    localparam logic [CNTW-1:0] c_LAST_CNT = CNTW'(ROW_BEATS - 1);
    localparam logic [PW:0]     c_RND      = {{PW{1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic [PW:0]     c_MAX      = {{(CW + 2){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic [PW:0]     c_MIN      = {{(CW + 2){1'b1}}, {(DW - 1){1'b0}}};

    logic [CW-1:0]       coef_q, coef_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic                sat_flag_q, sat_flag_d;

    logic                s1_valid_q;
    logic [LANES*PW-1:0] s1_prod_q;
    logic                s1_last_q;

    logic                out_valid_q;
    logic [LANES*DW-1:0] out_bar_q;
    logic                out_last_q;
    logic                s2_sat_q;

    logic [LANES*PW-1:0] w_prod;
    logic [LANES*DW-1:0] w_res;
    logic [LANES-1:0]    w_sat;

    logic                w_s2_adv;
    logic                w_s1_adv;
    logic                w_in_xfer;
    logic                w_out_xfer;

    // Stage 2 moves when empty or drained; stage 1 moves when it can hand off
    assign w_s2_adv   = !out_valid_q || out_ready;
    assign w_s1_adv   = !s1_valid_q || w_s2_adv;
    assign in_ready   = w_s1_adv;
    assign w_in_xfer  = in_valid && w_s1_adv;
    assign w_out_xfer = out_valid_q && out_ready;

    assign out_valid  = out_valid_q;
    assign out_bar    = out_bar_q;
    assign out_last   = out_last_q;
    assign sat_flag   = sat_flag_q;

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            logic [DW-1:0] w_lane;
            logic [PW-1:0] w_p;
            logic [PW:0]   w_rnd;
            logic [PW:0]   w_shf;
            logic          w_hi;
            logic          w_lo;

            // Both operands sign-extended to the full product width
            assign w_lane = in_bar[g*DW +: DW];
            assign w_prod[g*PW +: PW] = $signed({{CW{w_lane[DW-1]}}, w_lane})
                                      * $signed({{DW{coef_q[CW-1]}}, coef_q});

            // One guard bit keeps the rounding add from wrapping
            assign w_p   = s1_prod_q[g*PW +: PW];
            assign w_rnd = {w_p[PW-1], w_p} + c_RND;
            assign w_shf = $signed(w_rnd) >>> FRAC;
            assign w_hi  = $signed(w_shf) > $signed(c_MAX);
            assign w_lo  = $signed(w_shf) < $signed(c_MIN);

            assign w_res[g*DW +: DW] = w_hi ? c_MAX[DW-1:0] :
                                       w_lo ? c_MIN[DW-1:0] : w_shf[DW-1:0];
            assign w_sat[g] = w_hi || w_lo;
        end
    endgenerate

    // Next-state for coefficient, row counter and sticky flag (set beats clear)
    always_comb begin
        coef_d     = coef_q;
        cnt_d      = cnt_q;
        sat_flag_d = sat_flag_q;
        if (cfg_load) begin
            coef_d = cfg_coef;
        end
        if (w_in_xfer) begin
            cnt_d = (cnt_q == c_LAST_CNT) ? '0 : cnt_q + CNTW'(1);
        end
        if (w_out_xfer && s2_sat_q) begin
            sat_flag_d = 1'b1;
        end else if (sat_clr) begin
            sat_flag_d = 1'b0;
        end
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef_q     <= COEF_RST;
            cnt_q      <= '0;
            sat_flag_q <= 1'b0;
        end else begin
            coef_q     <= coef_d;
            cnt_q      <= cnt_d;
            sat_flag_q <= sat_flag_d;
        end
    end

    // Stage 1: capture raw products and the row-end tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_prod_q  <= '0;
            s1_last_q  <= 1'b0;
        end else if (w_s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_prod_q <= w_prod;
                s1_last_q <= (cnt_q == c_LAST_CNT);
            end
        end
    end

    // Stage 2: round, saturate and present; holds while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_bar_q   <= '0;
            out_last_q  <= 1'b0;
            s2_sat_q    <= 1'b0;
        end else if (w_s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_bar_q  <= w_res;
                out_last_q <= s1_last_q;
                s2_sat_q   <= |w_sat;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scale_lanes.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scale_lanes
//  Description : Directed self-checking bench for scale_lanes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scale_lanes;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cfg_coef;
    logic        cfg_load;
    logic        sat_clr;
    logic [63:0] in_bar;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_bar;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        sat_flag;

    scale_lanes dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_coef  (cfg_coef),
        .cfg_load  (cfg_load),
        .sat_clr   (sat_clr),
        .in_bar    (in_bar),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_bar   (out_bar),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] coef;
        logic [63:0] bar;
        logic [63:0] exp;
        logic        sat;
    } vec_t;

    typedef struct {
        logic [63:0] bar;
        logic        last;
    } exp_t;

    vec_t        tbl[7];
    exp_t        sb[$];
    logic [15:0] cur_coef;
    int          tb_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: floor((x*c + 2^11) / 2^12), clamped to signed 16 bits
    function automatic logic [63:0] model(input logic [63:0] b, input logic [15:0] c);
        logic [63:0] r;
        longint      p;
        for (int i = 0; i < 4; i++) begin
            p = longint'($signed(b[i*16 +: 16])) * longint'($signed(c));
            p = (p + 2048) >>> 12;
            if (p > 32767)  p = 32767;
            if (p < -32768) p = -32768;
            r[i*16 +: 16] = p[15:0];
        end
        return r;
    endfunction

    function automatic logic [63:0] mk(input int k);
        logic [15:0] l0, l1, l2;
        l0 = 16'(k * 37 - 300);
        l1 = 16'(-k * 53);
        l2 = 16'(k << 8);
        return {16'h5000, l2, l1, l0};
    endfunction

    // Continuous stream with optional output stall and mid-stream coefficient load
    task automatic stream(input int n, input int stall_at, input int stall_len,
                          input int load_at, input logic [15:0] load_val);
        int          sent = 0;
        int          got  = 0;
        int          cyc  = 0;
        logic [63:0] held = '0;
        exp_t        e;
        bit          stalled;
        while ((got < n) && (cyc < n + stall_len + 20)) begin
            stalled   = (cyc >= stall_at) && (cyc < stall_at + stall_len);
            in_valid  = (sent < n);
            in_bar    = mk(sent);
            out_ready = !stalled;
            cfg_load  = (sent == load_at) && (sent < n);
            cfg_coef  = load_val;
            #1;
            if (stalled) begin
                if (cyc == stall_at) held = out_bar;
                chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
                chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
                chk("stall_hold", out_bar, held);
            end
            if (in_valid && in_ready) begin
                e.bar  = model(in_bar, cur_coef);
                e.last = (tb_cnt == 15);
                sb.push_back(e);
                tb_cnt = (tb_cnt + 1) % 16;
                sent++;
            end
            if (cfg_load) cur_coef = load_val;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("stream_bar", out_bar, e.bar);
                    chk("stream_last", {63'd0, out_last}, {63'd0, e.last});
                end
                got++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        cfg_load  = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", 64'(got), 64'(n));
        sb.delete();
    endtask

    initial begin
        tbl[0] = '{16'h0400, 64'h00fc_00fd_00fe_00ff, 64'h003f_003f_0040_0040, 1'b0};
        tbl[1] = '{16'h0400, 64'h0001_0000_fffe_fffd, 64'h0000_0000_0000_ffff, 1'b0};
        tbl[2] = '{16'h0400, 64'h7fff_8000_0002_fffa, 64'h2000_e000_0001_ffff, 1'b0};
        tbl[3] = '{16'h0400, 64'h0006_fff9_0064_ff9c, 64'h0002_fffe_0019_ffe7, 1'b0};
        tbl[4] = '{16'h4000, 64'h0000_0001_e000_2000, 64'h0000_0004_8000_7fff, 1'b1};
        tbl[5] = '{16'hf000, 64'h8000_0005_7fff_0000, 64'h7fff_fffb_8001_0000, 1'b1};
        tbl[6] = '{16'h0800, 64'h0003_fffd_0001_ffff, 64'h0002_ffff_0001_0000, 1'b0};

        rst_n     = 1'b0;
        cfg_coef  = '0;
        cfg_load  = 1'b0;
        sat_clr   = 1'b0;
        in_bar    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tb_cnt    = 0;
        cur_coef  = 16'h0400;
        step();
        step();
        rst_n = 1'b1;
        step();

        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("rst_out_bar",   out_bar, 64'd0);
        chk("rst_out_last",  {63'd0, out_last},  64'd0);
        chk("rst_sat_flag",  {63'd0, sat_flag},  64'd0);

        // First vector runs on the reset coefficient (no load)
        for (int i = 0; i < 7; i++) begin
            if (i != 0) begin
                cfg_coef = tbl[i].coef;
                cfg_load = 1'b1;
            end
            sat_clr = 1'b1;
            step();
            cfg_load = 1'b0;
            sat_clr  = 1'b0;
            in_bar   = tbl[i].bar;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            tb_cnt++;
            chk("vec_lat1_valid", {63'd0, out_valid}, 64'd0);
            step();
            chk("vec_lat2_valid", {63'd0, out_valid}, 64'd1);
            chk("vec_bar", out_bar, tbl[i].exp);
            step();
            chk("vec_sat", {63'd0, sat_flag}, {63'd0, tbl[i].sat});
            chk("vec_drained", {63'd0, out_valid}, 64'd0);
        end

        // Saturating beat transferring while sat_clr is held: set wins
        cfg_coef = 16'h4000;
        cfg_load = 1'b1;
        sat_clr  = 1'b1;
        step();
        cfg_load = 1'b0;
        chk("clr_before", {63'd0, sat_flag}, 64'd0);
        in_bar   = 64'h0000_0000_e000_2000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        tb_cnt++;
        step();
        chk("clr_sat_bar", out_bar, 64'h0000_0000_8000_7fff);
        step();
        chk("clr_set_wins", {63'd0, sat_flag}, 64'd1);
        step();
        chk("clr_after", {63'd0, sat_flag}, 64'd0);
        sat_clr = 1'b0;

        // Unit coefficient stream with a 5-cycle output stall
        cfg_coef = 16'h1000;
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
        cur_coef = 16'h1000;
        stream(20, 6, 5, -1, 16'h0000);

        // Coefficient change mid-stream; later beats saturate lane 3
        stream(10, -1, 0, 3, 16'h2000);
        chk("load_sat_flag", {63'd0, sat_flag}, 64'd1);

        // Fill both stages, then reset with beats in flight
        out_ready = 1'b0;
        in_bar    = mk(1);
        in_valid  = 1'b1;
        step();
        step();
        in_valid  = 1'b0;
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_sat_flag",  {63'd0, sat_flag},  64'd0);
        chk("mid_rst_in_ready",  {63'd0, in_ready},  64'd1);
        step();
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tb_cnt    = 0;
        cur_coef  = 16'h0400;
        step();
        chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);

        // 32 beats from a fresh counter: row ends on outputs 15 and 31
        stream(32, -1, 0, -1, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
